decompose_l7: RTL and testbench

- Seventh-level sym4 analysis (decomposition) stage. It is the forward-direction counterpart of the level-7 reconstruction stage.
- Consumes the level-6 approximation stream a6, nominally one sample every 4 cycles.
- Applies the 8-tap lowpass and highpass analysis filters and downsamples by 2.
- Emits one paired (a7, d7) result every 8 cycles. The pair feeds the level-8 decomposer and the detail-coefficient store.

---
 rtl/decompose_l7_if.sv | 21 ++
 rtl/decompose_l7.sv | 153 +++++++++++++++
 tb/tb_decompose_l7.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/decompose_l7_if.sv
// Stream interface for the level-7 sym4 analysis stage: a6 samples in, paired (a7, d7) results out.
interface decompose_l7_if #(
    parameter int INTERNAL_WIDTH = 48
);
    logic                             din_valid;
    logic signed [INTERNAL_WIDTH-1:0] a6_in;
    logic                             dout_valid;
    logic signed [INTERNAL_WIDTH-1:0] a7_out;
    logic signed [INTERNAL_WIDTH-1:0] d7_out;
    logic                             sat_flag;

    modport master (
        output din_valid, a6_in,
        input  dout_valid, a7_out, d7_out, sat_flag
    );

    modport slave (
        input  din_valid, a6_in,
        output dout_valid, a7_out, d7_out, sat_flag
    );
endinterface

// File: rtl/decompose_l7.sv
// Level-7 sym4 analysis stage: 8-tap lowpass/highpass filters, decimate by 2, 4-cycle pipeline.
// Optional idle auto-flush of the window/phase is enabled by defining DECOMP_IDLE_FLUSH_EN.
module decompose_l7 #(
    parameter int INTERNAL_WIDTH = 48,
    parameter int COEF_WIDTH     = 25,
    parameter int COEF_FRAC      = 23,
    parameter logic signed [COEF_WIDTH-1:0] DEC_LO0 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_LO1 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_LO2 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_LO3 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_LO4 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_LO5 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_LO6 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_LO7 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_HI0 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_HI1 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_HI2 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_HI3 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_HI4 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_HI5 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_HI6 = '0,
    parameter logic signed [COEF_WIDTH-1:0] DEC_HI7 = '0,
    parameter int IDLE_TIMEOUT   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sclr,
    decompose_l7_if.slave bus
);
    localparam int IW = INTERNAL_WIDTH;
    localparam int CW = COEF_WIDTH;
    localparam int CF = COEF_FRAC;
    localparam int PW = IW + CW;      // product
    localparam int QW = PW + 1;       // 2-term partial sum
    localparam int SW = PW + 3;       // 8-term sum

    localparam logic [7:0][CW-1:0] LO = {DEC_LO7, DEC_LO6, DEC_LO5, DEC_LO4,
                                         DEC_LO3, DEC_LO2, DEC_LO1, DEC_LO0};
    localparam logic [7:0][CW-1:0] HI = {DEC_HI7, DEC_HI6, DEC_HI5, DEC_HI4,
                                         DEC_HI3, DEC_HI2, DEC_HI1, DEC_HI0};
    localparam logic [IW-1:0] SMAX = {1'b0, {(IW-1){1'b1}}};
    localparam logic [IW-1:0] SMIN = {1'b1, {(IW-1){1'b0}}};

    logic [7:0][IW-1:0] win, win_nxt;
    logic               phase;
    logic               launch;
    logic               flush;
    logic [3:1]         vld_pipe;

    logic [7:0][PW-1:0] prod_lo, prod_hi;
    logic [3:0][QW-1:0] part_lo, part_hi;
    logic [SW-1:0]      sum_lo, sum_hi;

    logic               ovf_lo, ovf_hi;
    logic [IW-1:0]      a7_c, d7_c;

    // Products are formed from the post-shift window so the launching sample is w0.
    assign win_nxt = {win[6:0], bus.a6_in};
    assign launch  = bus.din_valid & phase & ~sclr;

`ifdef DECOMP_IDLE_FLUSH_EN
    localparam int CNTW = $clog2(IDLE_TIMEOUT + 1);
    logic [CNTW-1:0] idle_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idle_cnt <= '0;
        else if (sclr || bus.din_valid)
            idle_cnt <= '0;
        else if (idle_cnt != CNTW'(IDLE_TIMEOUT))
            idle_cnt <= idle_cnt + 1'b1;
    end

    assign flush = ~bus.din_valid & (idle_cnt == CNTW'(IDLE_TIMEOUT - 1));
`else
    assign flush = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win   <= '0;
            phase <= 1'b0;
        end else if (sclr || flush) begin
            win   <= '0;
            phase <= 1'b0;
        end else if (bus.din_valid) begin
            win   <= win_nxt;
            phase <= ~phase;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_pipe <= '0;
        else if (sclr)
            vld_pipe <= '0;
        else
            vld_pipe <= {vld_pipe[2:1], launch};
    end

    // Datapath free-runs; only the valid bits qualify it.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 8; k++) begin
            prod_lo[k] <= PW'($signed(win_nxt[k])) * PW'($signed(LO[k]));
            prod_hi[k] <= PW'($signed(win_nxt[k])) * PW'($signed(HI[k]));
        end
        for (int j = 0; j < 4; j++) begin
            part_lo[j] <= QW'($signed(prod_lo[2*j])) + QW'($signed(prod_lo[2*j+1]));
            part_hi[j] <= QW'($signed(prod_hi[2*j])) + QW'($signed(prod_hi[2*j+1]));
        end
        sum_lo <= SW'($signed(part_lo[0])) + SW'($signed(part_lo[1]))
                + SW'($signed(part_lo[2])) + SW'($signed(part_lo[3]));
        sum_hi <= SW'($signed(part_hi[0])) + SW'($signed(part_hi[1]))
                + SW'($signed(part_hi[2])) + SW'($signed(part_hi[3]));
    end

    // Drop COEF_FRAC bits (floor); clamp when the bits above the kept field disagree with the sign.
    function automatic logic [IW:0] scale_sat(input logic [SW-1:0] s);
        logic [SW-CF-IW:0] top;
        top = s[SW-1:CF+IW-1];
        if ((&top) || (~|top))
            return {1'b0, s[CF+IW-1:CF]};
        else if (s[SW-1])
            return {1'b1, SMIN};
        else
            return {1'b1, SMAX};
    endfunction

    always_comb begin
        {ovf_lo, a7_c} = scale_sat(sum_lo);
        {ovf_hi, d7_c} = scale_sat(sum_hi);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dout_valid <= 1'b0;
            bus.a7_out     <= '0;
            bus.d7_out     <= '0;
            bus.sat_flag   <= 1'b0;
        end else if (sclr) begin
            bus.dout_valid <= 1'b0;
            bus.sat_flag   <= 1'b0;
        end else begin
            bus.dout_valid <= vld_pipe[3];
            if (vld_pipe[3]) begin
                bus.a7_out <= a7_c;
                bus.d7_out <= d7_c;
                if (ovf_lo || ovf_hi)
                    bus.sat_flag <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_decompose_l7.sv
// Directed bench for decompose_l7: three instances with impulse, single-tap and all-ones taps.
module tb_decompose_l7;
    localparam logic signed [47:0] MAX = 48'sh7FFF_FFFF_FFFF;
    localparam logic signed [47:0] MIN = 48'sh8000_0000_0000;

    logic clk = 1'b0;
    logic rst_n;
    logic sclr;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    decompose_l7_if #(.INTERNAL_WIDTH(48)) bi ();
    decompose_l7_if #(.INTERNAL_WIDTH(48)) bo ();
    decompose_l7_if #(.INTERNAL_WIDTH(48)) bs ();

    // Impulse taps LO=k+1, HI=-(k+1); needs a wider coefficient to hold 8.0.
    decompose_l7 #(
        .COEF_WIDTH(28),
        .DEC_LO0(28'sd8388608),  .DEC_LO1(28'sd16777216), .DEC_LO2(28'sd25165824), .DEC_LO3(28'sd33554432),
        .DEC_LO4(28'sd41943040), .DEC_LO5(28'sd50331648), .DEC_LO6(28'sd58720256), .DEC_LO7(28'sd67108864),
        .DEC_HI0(-28'sd8388608),  .DEC_HI1(-28'sd16777216), .DEC_HI2(-28'sd25165824), .DEC_HI3(-28'sd33554432),
        .DEC_HI4(-28'sd41943040), .DEC_HI5(-28'sd50331648), .DEC_HI6(-28'sd58720256), .DEC_HI7(-28'sd67108864)
    ) u_imp (.clk(clk), .rst_n(rst_n), .sclr(sclr), .bus(bi.slave));

    decompose_l7 #(
        .DEC_LO0(25'sd8388608)
    ) u_one (.clk(clk), .rst_n(rst_n), .sclr(sclr), .bus(bo.slave));

    decompose_l7 #(
        .DEC_LO0(25'sd8388608), .DEC_LO1(25'sd8388608), .DEC_LO2(25'sd8388608), .DEC_LO3(25'sd8388608),
        .DEC_LO4(25'sd8388608), .DEC_LO5(25'sd8388608), .DEC_LO6(25'sd8388608), .DEC_LO7(25'sd8388608)
    ) u_sat (.clk(clk), .rst_n(rst_n), .sclr(sclr), .bus(bs.slave));

    task automatic chk(input string tag, input logic signed [47:0] obs, input logic signed [47:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One cycle of stimulus to all instances; returns #1 after the edge that consumes it.
    task automatic cyc(input logic v, input logic signed [47:0] a, input logic clr);
        sclr = clr;
        bi.din_valid = v; bi.a6_in = a;
        bo.din_valid = v; bo.a6_in = a;
        bs.din_valid = v; bs.a6_in = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  t;
        logic ev;
        rst_n = 1'b0;
        sclr  = 1'b0;
        bi.din_valid = 1'b0; bi.a6_in = '0;
        bo.din_valid = 1'b0; bo.a6_in = '0;
        bs.din_valid = 1'b0; bs.a6_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_vld_imp", bi.dout_valid, 1'b0);
        chk1("rst_vld_one", bo.dout_valid, 1'b0);
        chk1("rst_vld_sat", bs.dout_valid, 1'b0);
        chk ("rst_a7_imp", bi.a7_out, 48'sd0);
        chk ("rst_d7_imp", bi.d7_out, 48'sd0);
        chk1("rst_sat_flag", bs.sat_flag, 1'b0);
        rst_n = 1'b1;

        // Impulse response: one 1000 then zeros, 4-cycle spacing.
        for (int c = 0; c < 36; c++) begin
            cyc((c % 4 == 0) && (c < 32), (c == 0) ? 48'sd1000 : 48'sd0, 1'b0);
            t  = c + 1;
            ev = (t % 8 == 0) && (t <= 32);
            chk1("imp_vld", bi.dout_valid, ev);
            if (ev) begin
                chk("imp_a7", bi.a7_out, 48'(250 * t));
                chk("imp_d7", bi.d7_out, 48'(-250 * t));
            end
        end
        cyc(1'b0, 48'sd0, 1'b1);

        // Parity: only odd-slot samples produce outputs; output holds when idle.
        for (int c = 0; c < 20; c++) begin
            cyc((c % 4 == 0) && (c < 16), 48'(5 + 2 * (c / 4)), 1'b0);
            t = c + 1;
            chk1("par_vld", bo.dout_valid, (t == 8) || (t == 16));
            if (t == 8)  begin chk("par_a7_1", bo.a7_out, 48'sd7);  chk("par_d7_1", bo.d7_out, 48'sd0); end
            if (t == 9)  chk("par_hold", bo.a7_out, 48'sd7);
            if (t == 16) begin chk("par_a7_2", bo.a7_out, 48'sd11); chk("par_d7_2", bo.d7_out, 48'sd0); end
        end
        cyc(1'b0, 48'sd0, 1'b1);

        // Back-to-back strobes: results two cycles apart.
        for (int c = 0; c < 10; c++) begin
            cyc(c < 4, 48'(c + 1), 1'b0);
            t = c + 1;
            chk1("b2b_vld", bo.dout_valid, (t == 5) || (t == 7));
            if (t == 5) chk("b2b_a7_1", bo.a7_out, 48'sd2);
            if (t == 7) chk("b2b_a7_2", bo.a7_out, 48'sd4);
        end
        cyc(1'b0, 48'sd0, 1'b1);

        // Saturation: positive clamp on all-ones taps, negative clamp on the impulse highpass.
        for (int c = 0; c < 12; c++) begin
            cyc(c < 8, MAX, 1'b0);
            t = c + 1;
            if (t == 4) chk1("sat_flag_pre", bs.sat_flag, 1'b0);
            if (t == 5) begin chk1("sat_vld", bs.dout_valid, 1'b1); chk("sat_a7_first", bs.a7_out, MAX); end
            if (t == 11) begin
                chk("sat_a7", bs.a7_out, MAX);
                chk("sat_d7_zero", bs.d7_out, 48'sd0);
                chk("sat_neg_d7", bi.d7_out, MIN);
                chk("sat_pos_a7", bi.a7_out, MAX);
                chk1("sat_flag_imp", bi.sat_flag, 1'b1);
            end
        end
        chk1("sat_flag_sticky", bs.sat_flag, 1'b1);
        cyc(1'b0, 48'sd0, 1'b1);
        chk1("sat_flag_sclr", bs.sat_flag, 1'b0);

        // sclr kills an in-flight launch and resets the phase.
        for (int c = 0; c < 18; c++) begin
            cyc((c == 0) || (c == 4) || (c == 10) || (c == 12),
                (c == 0) ? 48'sd9 : (c == 4) ? 48'sd3 : (c == 10) ? 48'sd21 : 48'sd6,
                c == 6);
            t = c + 1;
            chk1("sclr_vld", bo.dout_valid, t == 16);
            if (t == 16) chk("sclr_a7", bo.a7_out, 48'sd6);
        end
        cyc(1'b0, 48'sd0, 1'b1);

        // Long idle gap: window is flushed only when the idle-flush option is built in.
        for (int c = 0; c < 30; c++) begin
            cyc((c == 0) || (c == 21) || (c == 22), (c == 0) ? 48'sd1000 : 48'sd0, 1'b0);
            t = c + 1;
`ifdef DECOMP_IDLE_FLUSH_EN
            chk1("idle_vld", bi.dout_valid, t == 26);
            if (t == 26) begin chk("idle_a7", bi.a7_out, 48'sd0); chk("idle_d7", bi.d7_out, 48'sd0); end
`else
            chk1("idle_vld", bi.dout_valid, t == 25);
            if (t == 25) begin chk("idle_a7", bi.a7_out, 48'sd2000); chk("idle_d7", bi.d7_out, -48'sd2000); end
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
